adder_12_arb: RTL and testbench
===============================

# adder_12_arb

Round-robin arbiter and sequencer that shares one combinational `adder_12` partition (11 inputs `pi00..pi10`, 7 outputs `po0..po6`) among NREQ requesters. It registers the granted operand vector onto the partition inputs and captures the partition outputs into a per-requester response slot with valid/ready handshakes. The partition sits outside the block and connects through `add_pi`/`add_po`.

## Interface
- NREQ, 4, number of requesters (2..8)
- CNTW, 16, width of each grant counter (used only with the perf feature)
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- arb_en  in  1  1 = new grants allowed; 0 = in-flight operations drain, no new grants
- req_valid  in  NREQ  per-requester request valid
- req_data  in  11*NREQ  requester i operand vector in bits [11i+10:11i]; bit j drives `pi0j`/`pij`
- req_ready  out  NREQ  one-hot grant, combinational
- add_pi  out  11  registered drive to partition inputs, bit j = `pi` j
- add_po  in  7  partition outputs, bit j = `po` j
- rsp_valid  out  NREQ  per-requester result valid
- rsp_data  out  7*NREQ  requester i result in bits [7i+6:7i]
- rsp_ready  in  NREQ  per-requester result accept
- idle  out  1  no operation in flight and all response slots empty
- perf_clr  in  1  synchronous clear of grant counters
- grant_cnt  out  CNTW*NREQ  per-requester grant counters

## Operation
- busy[i] = slot_full[i] | (s1_vld & s1_id==i). Requester i is eligible when req_valid[i] & ~busy[i] & arb_en.
- The RR pointer `ptr` (reset 0) marks the highest-priority index. The winner is the first eligible index scanning ptr, ptr+1, … mod NREQ. req_ready is one-hot to the winner and all-zero when nothing is eligible.
- On a grant to i:
  - add_pi <= req_data[i]
  - s1_vld <= 1
  - s1_id <= i
  - ptr <= (i+1) mod NREQ
- Without a grant: s1_vld <= 0, and add_pi holds its last value.
- When s1_vld=1: rsp_data[s1_id] <= add_po and slot_full[s1_id] <= 1. The busy rule guarantees the slot is empty at that point.
- Pop: rsp_valid[i] & rsp_ready[i] clears slot_full[i] at the clock edge. rsp_data[i] holds its value until overwritten.
- A pop and a same-cycle grant for the same i are not possible because busy[i] is still 1. The slot is free from the next cycle.
- arb_en falling mid-operation: the op in stage 1 still completes into its slot.
- idle = ~s1_vld & ~|slot_full.
- Reset values: add_pi=0, s1_vld=0, s1_id=0, ptr=0, slot_full=0, rsp_valid=0, rsp_data=0, grant_cnt=0, idle=1.
- Asynchronous reset mid-operation discards the in-flight op and all slots.

## Timing
- Cycle T: handshake req_valid[i]&req_ready[i].
- Edge T→T+1: add_pi valid. add_po settles within cycle T+1 as a combinational path.
- Edge T+1→T+2: result captured; rsp_valid[i]=1 from cycle T+2.
- Latency from accept to rsp_valid is 2 cycles.
- Distinct requesters can be granted on consecutive cycles, giving 1 op/cycle.
- Same requester with rsp_ready held high: accept every 3 cycles (T, T+3, …).
- req_ready depends combinationally on req_valid, arb_en, slot state and ptr. No path from rsp_ready to req_ready.

## Configuration
- ADDER12_ARB_PERF_EN defined:
  - grant_cnt[i] increments on each grant to i and saturates at 2^CNTW-1.
  - perf_clr=1 zeroes all counters; clear wins over a same-cycle increment.
- Not defined: counters are not built, grant_cnt is tied to 0, and perf_clr is ignored. Ports remain in either build.

## Test plan
- Single request: NREQ=4, req_valid=0001, req_data[0]=11'h5A3, arb_en=1 → req_ready=0001 at T; add_pi=11'h5A3 at T+1; rsp_valid=0001 at T+2 and rsp_data[0] equals the partition model output for 11'h5A3.
- All four requesters valid continuously, rsp_ready=1111, ptr=0 → grants 0,1,2,3 on cycles T..T+3. Next grant to 0 occurs at T+4 (it became free at T+3 but ptr rotation favours it at T+4).
- Back-pressure: rsp_ready[1]=0 after its first result → requester 1 receives no further grant while the others keep being served. Raising rsp_ready[1] gives a pop that cycle and a grant to 1 on the next eligible RR turn.
- arb_en dropped the cycle after a grant → that result still arrives at T+2; no further req_ready; idle=1 once the slot is popped.
- Asynchronous reset asserted while s1_vld=1 and two slots full → all rsp_valid=0, idle=1 and ptr=0 immediately. The first post-reset grant goes to the lowest-index valid requester.
- With ADDER12_ARB_PERF_EN, CNTW=4: 20 grants to requester 2 → grant_cnt[2]=15 (saturated). perf_clr together with a grant → counter reads 0 next cycle. Without the macro, grant_cnt reads 0 throughout.

Source files
------------

// File: rtl/adder_12_arb_if.sv
// Requester-side request/response bundle for adder_12_arb.
// The master drives requests and accepts results; the slave is the arbiter.
interface adder_12_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [11*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [7*NREQ-1:0]    rsp_data;
  logic [NREQ-1:0]      rsp_ready;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/adder_12_arb.sv
// Round-robin arbiter sharing one external adder_12 partition among NREQ requesters.
// Define ADDER12_ARB_PERF_EN to build saturating per-requester grant counters.
module adder_12_arb #(
  parameter int NREQ = 4,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arb_en,
  adder_12_arb_if.slave        bus,
  output logic [10:0]          add_pi,
  input  logic [6:0]           add_po,
  output logic                 idle,
  input  logic                 perf_clr,
  output logic [CNTW*NREQ-1:0] grant_cnt
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [10:0]        r_add_pi;
  logic               r_s1_vld;
  logic [PW-1:0]      r_s1_id;
  logic [PW-1:0]      r_ptr;
  logic [NREQ-1:0]    r_slot_full;
  logic [7*NREQ-1:0]  r_rsp_data;

  logic [NREQ-1:0]    w_s1_oh;
  logic [NREQ-1:0]    w_elig;
  logic               w_any;
  logic [PW-1:0]      w_gnt_id;
  logic [PW-1:0]      w_ptr_nxt;
  logic [NREQ-1:0]    w_req_ready;
  logic [NREQ-1:0]    w_slot_nxt;

  // First eligible index scanning from ptr upward with wrap.
  function automatic logic [PW-1:0] f_pick(input logic [NREQ-1:0] elig, input logic [PW-1:0] ptr);
    logic [PW-1:0] pick;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      else             idx = idx;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  // Busy mask, eligibility, winner and one-hot grant.
  always_comb begin
    w_s1_oh     = '0;
    w_req_ready = '0;
    if (r_s1_vld) w_s1_oh[r_s1_id] = 1'b1;
    else          w_s1_oh = '0;
    w_elig   = bus.req_valid & ~(r_slot_full | w_s1_oh) & {NREQ{arb_en}};
    w_any    = |w_elig;
    w_gnt_id = f_pick(w_elig, r_ptr);
    if (w_any) w_req_ready[w_gnt_id] = 1'b1;
    else       w_req_ready = '0;
    w_ptr_nxt = (w_gnt_id == PW'(NREQ - 1)) ? '0 : w_gnt_id + PW'(1);
  end

  // Slot occupancy: capture from stage 1 sets, pop clears; busy keeps them disjoint.
  always_comb begin
    w_slot_nxt = r_slot_full & ~bus.rsp_ready;
    if (r_s1_vld) w_slot_nxt[r_s1_id] = 1'b1;
    else          w_slot_nxt = w_slot_nxt;
  end

  // Operand register, stage-1 tag, RR pointer and response slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_add_pi    <= 11'd0;
      r_s1_vld    <= 1'b0;
      r_s1_id     <= '0;
      r_ptr       <= '0;
      r_slot_full <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_s1_vld    <= w_any;
      r_slot_full <= w_slot_nxt;
      if (w_any) begin
        r_add_pi <= bus.req_data[int'(w_gnt_id)*11 +: 11];
        r_s1_id  <= w_gnt_id;
        r_ptr    <= w_ptr_nxt;
      end
      if (r_s1_vld) begin
        r_rsp_data[int'(r_s1_id)*7 +: 7] <= add_po;
      end
    end
  end

  assign add_pi        = r_add_pi;
  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_slot_full;
  assign bus.rsp_data  = r_rsp_data;
  assign idle          = ~r_s1_vld & ~(|r_slot_full);

`ifdef ADDER12_ARB_PERF_EN
  logic [NREQ-1:0][CNTW-1:0] r_cnt;

  // Grant counters: clear beats increment, saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (perf_clr) begin
      r_cnt <= '0;
    end else if (w_any && (r_cnt[w_gnt_id] != {CNTW{1'b1}})) begin
      r_cnt[w_gnt_id] <= r_cnt[w_gnt_id] + CNTW'(1);
    end
  end

  assign grant_cnt = r_cnt;
`else
  logic w_unused_perf_clr;
  assign w_unused_perf_clr = perf_clr;
  assign grant_cnt         = '0;
`endif
endmodule

// File: tb/tb_adder_12_arb.sv
// Directed bench for adder_12_arb with a behavioural adder_12 partition model.
module tb_adder_12_arb;
  localparam int NREQ = 4;
  localparam int CNTW = 4;
  localparam logic [10:0] D0 = 11'h5A3;
  localparam logic [10:0] D1 = 11'h0FF;
  localparam logic [10:0] D2 = 11'h700;
  localparam logic [10:0] D3 = 11'h2AA;
  // Hand-computed partition outputs for D0..D3.
  localparam logic [6:0] P0 = 7'h11;
  localparam logic [6:0] P1 = 7'h26;
  localparam logic [6:0] P2 = 7'h59;
  localparam logic [6:0] P3 = 7'h5F;

  logic                 clk;
  logic                 rst_n;
  logic                 arb_en;
  logic [10:0]          add_pi;
  logic [6:0]           add_po;
  logic                 idle;
  logic                 perf_clr;
  logic [CNTW*NREQ-1:0] grant_cnt;

  int checks = 0;
  int errors = 0;

  adder_12_arb_if #(.NREQ(NREQ)) bus ();

  adder_12_arb #(.NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_en    (arb_en),
    .bus       (bus),
    .add_pi    (add_pi),
    .add_po    (add_po),
    .idle      (idle),
    .perf_clr  (perf_clr),
    .grant_cnt (grant_cnt)
  );

  // Partition: a = pi[4:0], b = pi[9:5], cin = pi[10]; po = {parity(pi), a+b+cin}.
  function automatic logic [6:0] part_model(input logic [10:0] pi);
    logic [5:0] s;
    s = {1'b0, pi[4:0]} + {1'b0, pi[9:5]} + {5'd0, pi[10]};
    return {^pi, s};
  endfunction

  assign add_po = part_model(add_pi);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    arb_en        = 1'b0;
    perf_clr      = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  int          seq_a [8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  int          seq_b [12] = '{0, 1, 2, 3, 0, 2, 3, 0, 2, 3, 0, 1};
  int          ngnt;
  logic [3:0]  cnt_exp;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    arb_en        = 1'b0;
    perf_clr      = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_data  = {D3, D2, D1, D0};
    #2;
    check("rst_idle", idle, 1'b1);
    check("rst_rsp_valid", bus.rsp_valid, 4'b0000);
    check("rst_add_pi", add_pi, 11'h000);
    check("rst_grant_cnt", grant_cnt, 16'h0000);
    do_reset();

    // Single request
    arb_en = 1'b1; bus.req_valid = 4'b0001; #1;
    check("single_ready_T", bus.req_ready, 4'b0001);
    tick(); bus.req_valid = 4'b0000; #1;
    check("single_add_pi", add_pi, D0);
    check("single_busy_idle", idle, 1'b0);
    check("single_rsp_T1", bus.rsp_valid, 4'b0000);
    tick();
    check("single_rsp_T2", bus.rsp_valid, 4'b0001);
    check("single_rsp_data", bus.rsp_data[6:0], P0);
    bus.rsp_ready = 4'b0001;
    tick();
    check("single_pop", bus.rsp_valid, 4'b0000);
    check("single_idle", idle, 1'b1);

    // All four continuously valid, full drain
    do_reset();
    arb_en = 1'b1; bus.req_valid = 4'b1111; bus.rsp_ready = 4'b1111; #1;
    for (int c = 0; c < 8; c++) begin
      check($sformatf("rr_grant_c%0d", c), bus.req_ready, 4'b0001 << seq_a[c]);
      if (c == 1) check("rr_add_pi_c1", add_pi, D0);
      if (c == 2) begin
        check("rr_rsp_valid_c2", bus.rsp_valid, 4'b0001);
        check("rr_rsp0_c2", bus.rsp_data[6:0], P0);
      end
      if (c == 3) begin
        check("rr_rsp_valid_c3", bus.rsp_valid, 4'b0010);
        check("rr_rsp1_c3", bus.rsp_data[13:7], P1);
      end
      if (c == 4) begin
        check("rr_add_pi_c4", add_pi, D3);
        check("rr_rsp2_c4", bus.rsp_data[20:14], P2);
      end
      if (c == 5) check("rr_rsp3_c5", bus.rsp_data[27:21], P3);
      tick();
    end

    // Back-pressure on requester 1
    do_reset();
    arb_en = 1'b1; bus.req_valid = 4'b1111; bus.rsp_ready = 4'b1101; #1;
    for (int c = 0; c < 12; c++) begin
      if (c == 8) begin
        bus.rsp_ready = 4'b1111;
        #1;
        check("bp_rsp1_held", bus.rsp_valid[1], 1'b1);
      end
      if (c == 9) check("bp_rsp1_popped", bus.rsp_valid[1], 1'b0);
      check($sformatf("bp_grant_c%0d", c), bus.req_ready, 4'b0001 << seq_b[c]);
      tick();
    end

    // arb_en dropped the cycle after a grant
    do_reset();
    arb_en = 1'b1; bus.req_valid = 4'b0100; #1;
    check("drain_grant", bus.req_ready, 4'b0100);
    tick(); arb_en = 1'b0; bus.req_valid = 4'b0110; #1;
    check("drain_no_grant_T1", bus.req_ready, 4'b0000);
    tick();
    check("drain_rsp_T2", bus.rsp_valid, 4'b0100);
    check("drain_rsp_data", bus.rsp_data[20:14], P2);
    check("drain_no_grant_T2", bus.req_ready, 4'b0000);
    bus.rsp_ready = 4'b0100;
    tick();
    check("drain_idle", idle, 1'b1);
    check("drain_no_grant_T3", bus.req_ready, 4'b0000);

    // Asynchronous reset with stage 1 busy and two slots full
    do_reset();
    arb_en = 1'b1; bus.req_valid = 4'b0111; bus.rsp_ready = 4'b0000;
    tick(); tick(); tick();
    check("areset_pre_slots", bus.rsp_valid, 4'b0011);
    check("areset_pre_idle", idle, 1'b0);
    rst_n = 1'b0; #1;
    check("areset_rsp_valid", bus.rsp_valid, 4'b0000);
    check("areset_idle", idle, 1'b1);
    check("areset_add_pi", add_pi, 11'h000);
    bus.req_valid = 4'b1010;
    tick(); rst_n = 1'b1; #1;
    check("areset_first_grant", bus.req_ready, 4'b0010);

    // Grant counter saturation and clear
    do_reset();
    arb_en = 1'b1; bus.req_valid = 4'b0100; bus.rsp_ready = 4'b1111; #1;
    ngnt = 0;
    for (int c = 0; c < 200 && ngnt < 20; c++) begin
      if (bus.req_ready[2]) ngnt++;
      tick();
      if (ngnt == 3 && bus.rsp_valid == 4'b0000 && idle == 1'b0) begin
`ifdef ADDER12_ARB_PERF_EN
        cnt_exp = 4'd3;
`else
        cnt_exp = 4'd0;
`endif
        check("cnt_after_3", grant_cnt[11:8], cnt_exp);
      end
    end
    check("cnt_grants_seen", ngnt, 20);
`ifdef ADDER12_ARB_PERF_EN
    cnt_exp = 4'd15;
`else
    cnt_exp = 4'd0;
`endif
    check("cnt_saturated", grant_cnt[11:8], cnt_exp);
    check("cnt_other_zero", grant_cnt[7:0], 8'h00);
    for (int c = 0; c < 10 && !bus.req_ready[2]; c++) tick();
    check("cnt_clr_grant_present", bus.req_ready, 4'b0100);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check("cnt_cleared", grant_cnt, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
